// File: rtl/hpdcache_rsp_demux_buf_pkg.sv
// rtl/hpdcache_rsp_demux_buf_pkg.sv - slot depth constants and occupancy helper for the response demux buffer
package hpdcache_rsp_demux_buf_pkg;

  // Every destination slot holds at most two responses.
  localparam int unsigned SLOT_DEPTH = 2;
  localparam logic [1:0]  SLOT_FULL  = 2'd2;

  // A slot can take a new entry unless it already holds SLOT_DEPTH entries.
  function automatic logic slot_has_room(input logic [1:0] count);
    return count != SLOT_FULL;
  endfunction

endpackage

// File: rtl/hpdcache_rsp_demux_slot.sv
// rtl/hpdcache_rsp_demux_slot.sv - two-entry FIFO slot holding responses for one destination
module hpdcache_rsp_demux_slot
  import hpdcache_rsp_demux_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [SLOT_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic                                  wr_ptr_q;
  logic                                  rd_ptr_q;
  logic [1:0]                            count_q;
  logic                                  do_push;
  logic                                  do_pop;

  // A full slot never takes a push and an empty slot never pops.
  assign do_push = push_i && slot_has_room(count_q);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // Storage, pointers and occupancy; a push and pop together leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is forced to zero when the slot is empty so stale data never leaks out.
  assign valid_o = (count_q != 2'd0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/hpdcache_rsp_demux_buf.sv
// rtl/hpdcache_rsp_demux_buf.sv - buffered response demux, one 2-entry slot per destination; optional err_o under HPDCACHE_RSP_DEMUX_ERR_EN
module hpdcache_rsp_demux_buf
  import hpdcache_rsp_demux_buf_pkg::*;
#(
  parameter  int unsigned NOUTPUT    = 2,
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned SEL_WIDTH  = $clog2(NOUTPUT)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [SEL_WIDTH-1:0]                 sel_i,
  input  logic [DATA_WIDTH-1:0]                data_i,
  output logic [NOUTPUT-1:0]                   valid_o,
  input  logic [NOUTPUT-1:0]                   ready_i,
  output logic [NOUTPUT-1:0][DATA_WIDTH-1:0]   data_o
`ifdef HPDCACHE_RSP_DEMUX_ERR_EN
  ,
  output logic                                 err_o
`endif
);

  typedef logic [SEL_WIDTH-1:0]  sel_t;
  typedef logic [DATA_WIDTH-1:0] payload_t;

  logic [NOUTPUT-1:0] sel_hit;
  logic [NOUTPUT-1:0] full;
  logic [NOUTPUT-1:0] push;
  logic [NOUTPUT-1:0] pop;
  logic [1:0]         count [NOUTPUT];
  payload_t           push_data;

  // One-hot decode of the selector; out-of-range selectors hit no slot.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < NOUTPUT; k++) begin
      sel_hit[k] = (sel_i == sel_t'(k));
    end
  end

  // Ready looks only at the target slot's occupancy, never at downstream ready.
  assign ready_o   = ~|(sel_hit & full);
  assign push      = {NOUTPUT{valid_i}} & sel_hit & ~full;
  assign pop       = valid_o & ready_i;
  assign push_data = data_i;

  for (genvar k = 0; k < NOUTPUT; k++) begin : g_slot
    assign full[k] = !slot_has_room(count[k]);

    hpdcache_rsp_demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .data_i  (push_data),
      .valid_o (valid_o[k]),
      .head_o  (data_o[k]),
      .count_o (count[k])
    );
  end

`ifdef HPDCACHE_RSP_DEMUX_ERR_EN
  logic in_range;
  logic err_q;

  assign in_range = |sel_hit;

  // Sticky flag: set by any accepted out-of-range transaction, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (valid_i && ready_o && !in_range) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_hpdcache_rsp_demux_buf.sv
// tb/tb_hpdcache_rsp_demux_buf.sv - randomized and directed bench with queue-based reference model
module tb_hpdcache_rsp_demux_buf;

  localparam int N  = 3;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid;
  logic              ready_o;
  logic [1:0]        sel;
  logic [DW-1:0]     data;
  logic [N-1:0]      valid_o;
  logic [N-1:0]      ready_i;
  logic [N-1:0][DW-1:0] data_o;
`ifdef HPDCACHE_RSP_DEMUX_ERR_EN
  logic              err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q   [N][$];
  logic [DW-1:0] got [N][$];

  always #5 clk = ~clk;

  hpdcache_rsp_demux_buf #(
    .NOUTPUT    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (valid),
    .ready_o (ready_o),
    .sel_i   (sel),
    .data_i  (data),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
`ifdef HPDCACHE_RSP_DEMUX_ERR_EN
    ,
    .err_o   (err)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-destination queues of at most two entries.
  function automatic logic m_ready();
    if (sel >= 2'(N)) return 1'b1;
    return q[sel].size() < 2;
  endfunction

  function automatic logic [N-1:0] m_valid();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = (q[k].size() != 0);
    return v;
  endfunction

  function automatic logic [N-1:0][DW-1:0] m_data();
    logic [N-1:0][DW-1:0] d;
    for (int k = 0; k < N; k++) d[k] = (q[k].size() != 0) ? q[k][0] : '0;
    return d;
  endfunction

  always @(posedge clk) begin : model_upd
    logic acc;
    if (rst_n) begin
      acc = valid && m_ready();
      for (int k = 0; k < N; k++)
        if (q[k].size() != 0 && ready_i[k]) void'(q[k].pop_front());
      if (acc && sel < 2'(N)) q[sel].push_back(data);
    end
  end

  always @(negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      got[k].delete();
    end
  end

  // Compare process: outputs checked against the model every cycle.
  always @(negedge clk) begin
    chk("valid_o", 64'(valid_o), 64'(m_valid()));
    chk("data_o",  64'(data_o),  64'(m_data()));
    chk("ready_o", 64'(ready_o), 64'(m_ready()));
    if (rst_n)
      for (int k = 0; k < N; k++)
        if (valid_o[k] && ready_i[k]) got[k].push_back(data_o[k]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    for (int k = 0; k < N; k++) got[k].delete();
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; sel = '0; data = '0; ready_i = '0;
    #12;
    chk("reset_valid", 64'(valid_o), 64'h0);
    chk("reset_data",  64'(data_o),  64'h0);
    chk("reset_ready", 64'(ready_o), 64'h1);
`ifdef HPDCACHE_RSP_DEMUX_ERR_EN
    chk("reset_err", 64'(err), 64'h0);
`endif
    step();
    rst_n = 1'b1;

    // Single push to destination 2, downstream stalled.
    valid = 1'b1; sel = 2'd2; data = 16'h00A5; ready_i = '0;
    step();
    valid = 1'b0;
    #1;
    chk("s32_valid", 64'(valid_o), 64'h4);
    chk("s32_data2", 64'(data_o[2]), 64'h00A5);
    chk("s32_data0", 64'(data_o[0]), 64'h0);
    ready_i = '1;
    step(); step();

    // Fill destination 1, stall third push, then drain in order.
    clear_got();
    ready_i = 3'b101;
    valid = 1'b1; sel = 2'd1; data = 16'h0011;
    step();
    data = 16'h0022;
    step();
    data = 16'h0033;
    #1;
    chk("s33_stall", 64'(ready_o), 64'h0);
    ready_i = 3'b111;
    step();
    ready_i = 3'b101;
    #1;
    chk("s33_resume", 64'(ready_o), 64'h1);
    step();
    valid = 1'b0; ready_i = 3'b111;
    repeat (4) step();
    chk("s33_cnt", 64'(got[1].size()), 64'd3);
    if (got[1].size() == 3) begin
      chk("s33_o0", 64'(got[1][0]), 64'h11);
      chk("s33_o1", 64'(got[1][1]), 64'h22);
      chk("s33_o2", 64'(got[1][2]), 64'h33);
    end

    // Back-to-back alternating destinations at full rate.
    clear_got();
    ready_i = 3'b111;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; sel = 2'(i % 2); data = 16'(16'h0100 + i);
      #1;
      chk("s34_ready", 64'(ready_o), 64'h1);
      step();
    end
    valid = 1'b0;
    step(); step();
    chk("s34_cnt0", 64'(got[0].size()), 64'd4);
    chk("s34_cnt1", 64'(got[1].size()), 64'd4);
    if (got[0].size() == 4 && got[1].size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("s34_d0", 64'(got[0][i]), 64'(16'h0100 + 2 * i));
        chk("s34_d1", 64'(got[1][i]), 64'(16'h0101 + 2 * i));
      end

    // Out-of-range selector is accepted and dropped.
    ready_i = '0;
    valid = 1'b1; sel = 2'd3; data = 16'hBEEF;
    #1;
    chk("s35_ready", 64'(ready_o), 64'h1);
    step();
    valid = 1'b0;
    #1;
    chk("s35_valid", 64'(valid_o), 64'h0);
`ifdef HPDCACHE_RSP_DEMUX_ERR_EN
    chk("s35_err", 64'(err), 64'h1);
    step();
    chk("s35_err_sticky", 64'(err), 64'h1);
`endif

    // Fill destination 0, then asynchronous reset between edges.
    valid = 1'b1; sel = 2'd0; data = 16'h0001;
    step();
    data = 16'h0002;
    step();
    valid = 1'b0;
    chk("s36_full", 64'(valid_o[0]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("s36_valid_drop", 64'(valid_o), 64'h0);
    chk("s36_ready", 64'(ready_o), 64'h1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    ready_i = '1;
    clear_got();
    repeat (3) step();
    chk("s36_no_stale", 64'(got[0].size()), 64'd0);
    chk("s36_valid_after", 64'(valid_o), 64'h0);
`ifdef HPDCACHE_RSP_DEMUX_ERR_EN
    chk("s36_err_clr", 64'(err), 64'h0);
`endif

    // Randomized traffic; a stalled transaction is held until accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!(valid && !m_ready())) begin
        valid = ($urandom_range(0, 3) != 0);
        sel   = 2'($urandom_range(0, 3));
        data  = 16'($urandom);
      end
      for (int k = 0; k < N; k++) ready_i[k] = ($urandom_range(0, 3) != 0);
      step();
    end
    valid = 1'b0; ready_i = '1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
